// File: rtl/aes_pkg.sv
// Shared AES datapath constants, FSM state type and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int BYTE     = 8;
  localparam int WORD     = 32;
  localparam int SENTENCE = 128;

  localparam logic [BYTE-1:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Multiply by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
    return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? GF_POLY : '0);
  endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns transform of one 32-bit column (row-0 byte in the MSB).
module inv_mix_word
  import aes_pkg::*;
(
  input  logic [WORD-1:0] inpt,
  output logic [WORD-1:0] oupt
);

  // a[3] is row 0 (MSB) down to a[0] as row 3.
  logic [3:0][BYTE-1:0] a;
  logic [3:0][BYTE-1:0] x2, x4, x8;
  logic [3:0][BYTE-1:0] m9, mb, md, me;

  always_comb begin
    a  = inpt;
    x2 = '0;
    x4 = '0;
    x8 = '0;
    m9 = '0;
    mb = '0;
    md = '0;
    me = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  always_comb begin
    oupt = {me[3] ^ mb[2] ^ md[1] ^ m9[0],
            m9[3] ^ me[2] ^ mb[1] ^ md[0],
            md[3] ^ m9[2] ^ me[1] ^ mb[0],
            mb[3] ^ md[2] ^ m9[1] ^ me[0]};
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine with valid/ready in and out.
// Define INV_MIX_COL_PAR_EN to compute all four columns in a single CALC cycle.
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SENTENCE-1:0] inpt,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SENTENCE-1:0] oupt,
  output logic                out_valid,
  input  logic                out_ready
);

  // Index 3 holds column 0 (the MSB word) so packing matches the ports directly.
  state_e               state_q, state_d;
  logic [3:0][WORD-1:0] src_q, src_d;
  logic [3:0][WORD-1:0] res_q, res_d;

`ifdef INV_MIX_COL_PAR_EN
  logic [3:0][WORD-1:0] par_res;

  for (genvar g = 0; g < 4; g++) begin : g_col
    inv_mix_word u_inv_mix_word (
      .inpt (src_q[g]),
      .oupt (par_res[g])
    );
  end
`else
  logic [1:0]      col_q, col_d;
  logic [WORD-1:0] col_src;
  logic [WORD-1:0] col_res;

  always_comb begin
    col_src = src_q[2'd3 - col_q];
  end

  inv_mix_word u_inv_mix_word (
    .inpt (col_src),
    .oupt (col_res)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      res_q   <= '0;
`ifndef INV_MIX_COL_PAR_EN
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
`ifndef INV_MIX_COL_PAR_EN
      col_q   <= col_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifndef INV_MIX_COL_PAR_EN
    col_d     = col_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          src_d   = inpt;
          res_d   = '0;
          state_d = CALC;
`ifndef INV_MIX_COL_PAR_EN
          col_d   = '0;
`endif
        end
      end
      CALC: begin
`ifdef INV_MIX_COL_PAR_EN
        res_d   = par_res;
        state_d = DONE;
`else
        res_d[2'd3 - col_q] = col_res;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    oupt = res_q;
  end

endmodule
